mdr_result_stage: RTL and testbench
===================================

MDR_RESULT_STAGE -- requirements
Module: mdr_result_stage

Interface
REQ-001 SHALL have parameter DW, 16, operand/result width in bits (DW >= 4).
REQ-002 SHALL have parameter DEPTH, 4, result buffer entries (power of two, >= 2).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_flag  input  1  one-cycle "operation done" strobe from the MDR datapath.
REQ-006 SHALL have port i_mode  input  2  mdr_mode_e: MULT=0, DIV=1, SQRT=2, RSVD=3; sampled with i_flag.
REQ-007 SHALL have port i_acc  input  2*DW+1  raw accumulator; field P = i_acc[2*DW:1], LO = P[DW-1:0], HI = P[2*DW-1:DW].
REQ-008 SHALL have port i_neg  input  1  negate primary result (product or quotient).
REQ-009 SHALL have port i_rneg  input  1  negate remainder (DIV only).
REQ-010 SHALL have port i_dz  input  1  divide-by-zero indication (DIV only).
REQ-011 SHALL have port i_ready  input  1  downstream accepts head entry.
REQ-012 SHALL have port o_valid  output  1  head entry available.
REQ-013 SHALL have port o_data  output  DW  head primary result.
REQ-014 SHALL have port o_rem  output  DW  head secondary result (MULT: high half, DIV: remainder, SQRT: remainder).
REQ-015 SHALL have port o_err  output  1  head entry error (overflow, divide-by-zero, or reserved mode).
REQ-016 SHALL have port o_full  output  1  buffer holds DEPTH entries.
REQ-017 SHALL have port o_count  output  $clog2(DEPTH)+1  occupied entries.
REQ-018 SHALL have port o_drop  output  1  one-cycle pulse: strobe lost because buffer full.

Function
REQ-019 SHALL compute the entry combinationally from inputs on the i_flag cycle and write it at that clock edge; o_valid SHALL rise the following cycle (latency 1) when the buffer was empty.
REQ-020 MULT: Pn = i_neg ? -P : P (2*DW two's complement); o_data = Pn[DW-1:0]; o_rem = Pn[2*DW-1:DW]; err = 1 unless Pn[2*DW-1:DW-1] are all equal.
REQ-021 DIV: o_data = i_neg ? -LO : LO; o_rem = i_rneg ? -HI : HI; err = i_dz.
REQ-022 SQRT: o_data = LO, o_rem = HI; i_neg, i_rneg and i_dz ignored; err = 0.
REQ-023 RSVD: entry SHALL be written with o_data = o_rem = 0 and err = 1.
REQ-024 Pop SHALL occur when o_valid & i_ready; o_data/o_rem/o_err SHALL hold stable while o_valid & ~i_ready.
REQ-025 Push SHALL be accepted when count < DEPTH, or when count == DEPTH and a pop occurs in the same cycle; count is then unchanged.
REQ-026 Push refused SHALL leave state unchanged and assert o_drop for exactly the following cycle.
REQ-027 Read/write pointers SHALL wrap modulo DEPTH; entries SHALL be delivered in FIFO order.
REQ-028 o_full SHALL equal (o_count == DEPTH); o_valid SHALL equal (o_count != 0); both SHALL be registered-state derived, with no combinational path from i_flag.
REQ-029 Pop on empty SHALL be ignored.

Reset
REQ-030 rst high SHALL immediately clear pointers, count, o_valid, o_full, o_drop, o_err, o_data and o_rem to 0, discarding stored entries.
REQ-031 An i_flag coincident with rst SHALL be discarded.
REQ-032 The first push SHALL be accepted on the first rising edge after rst deasserts.

Structure
REQ-033 pkg_system_mdr SHALL hold mdr_mode_e, the result_entry_t struct {data, rem, err}, and the default DW.
REQ-034 Storage SHALL be a sub-module mdr_result_fifo (parametrised DW, DEPTH); result formatting SHALL remain in the top.

Verification (DW=16, DEPTH=4)
REQ-035 MULT, i_acc = 33'h0_0000_000C, i_neg=1 -> next cycle o_valid=1, o_data=16'hFFFA, o_rem=16'hFFFF, o_err=0.
REQ-036 MULT, i_acc = 33'h0_0002_BF20 (300*300) -> o_data=16'h5F90, o_rem=16'h0001, o_err=1.
REQ-037 DIV, i_acc = 33'h0_0002_0010 (17/2), i_neg=1, i_rneg=0 -> o_data=16'hFFF8, o_rem=16'h0001, o_err=0; repeat with i_dz=1 -> o_err=1.
REQ-038 Five strobes with i_ready=0 -> o_count=4, o_full=1, o_drop pulses once after the fifth; then i_ready=1 -> four entries delivered in order, o_valid=0 after the last.
REQ-039 Full buffer, i_flag and i_ready in the same cycle -> push accepted, o_drop=0, o_count stays 4.
REQ-040 Two entries stored, rst pulsed mid-cycle -> o_valid=0 and o_count=0 before the next clock edge.

Source files
------------

// File: rtl/mdr_result_stage_pkg.sv
// Purpose: shared types and defaults for the MDR result stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: mdr_mode_e, result_entry_t {data, rem, err}, default DW/DEPTH.
package pkg_system_mdr;

  localparam int MDR_DW    = 16;
  localparam int MDR_DEPTH = 4;

  typedef enum logic [1:0] {
    MULT = 2'd0,
    DIV  = 2'd1,
    SQRT = 2'd2,
    RSVD = 2'd3
  } mdr_mode_e;

  // Entry layout at the default width; the top mirrors this layout at its
  // own DW so the stage stays parametric.
  typedef struct packed {
    logic [MDR_DW-1:0] data;
    logic [MDR_DW-1:0] rem;
    logic              err;
  } result_entry_t;

endpackage

// File: rtl/mdr_result_stage_if.sv
// Purpose: handshake/bus bundle between the MDR datapath, result stage and consumer.
// Latency: n/a (wires only).
// Backpressure: i_ready from consumer; o_full/o_drop report buffer state.
// Ports: i_flag/i_mode/i_acc/i_neg/i_rneg/i_dz strobe in an operation result,
//        i_ready pops the head, o_* present the head entry and buffer status.
interface mdr_result_stage_if
  import pkg_system_mdr::*;
#(
  parameter int DW    = MDR_DW,
  parameter int DEPTH = MDR_DEPTH
);

  logic                     i_flag;
  logic [1:0]               i_mode;
  logic [2*DW:0]            i_acc;
  logic                     i_neg;
  logic                     i_rneg;
  logic                     i_dz;
  logic                     i_ready;
  logic                     o_valid;
  logic [DW-1:0]            o_data;
  logic [DW-1:0]            o_rem;
  logic                     o_err;
  logic                     o_full;
  logic [$clog2(DEPTH):0]   o_count;
  logic                     o_drop;

  // master: datapath/consumer side; slave: the result stage
  modport master (
    output i_flag, i_mode, i_acc, i_neg, i_rneg, i_dz, i_ready,
    input  o_valid, o_data, o_rem, o_err, o_full, o_count, o_drop
  );

  modport slave (
    input  i_flag, i_mode, i_acc, i_neg, i_rneg, i_dz, i_ready,
    output o_valid, o_data, o_rem, o_err, o_full, o_count, o_drop
  );

endinterface

// File: rtl/mdr_result_stage_fifo.sv
// Purpose: DEPTH-entry FIFO holding formatted results (mdr_result_fifo).
// Latency: 1 cycle push-to-valid; head read is combinational from registered state.
// Backpressure: push refused when full unless a pop happens the same cycle; refusal pulses o_drop.
// Ports: clk/rst, i_push/i_wdata write side, i_pop read side, o_rdata head,
//        o_valid/o_full/o_count status, o_drop refused-push pulse.
module mdr_result_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [2*DW:0]            i_wdata,
  input  logic                     i_pop,
  output logic [2*DW:0]            o_rdata,
  output logic                     o_valid,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int W  = 2*DW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_drop;

  logic w_full;
  logic w_valid;
  logic w_pop;
  logic w_push;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_valid = (r_count != '0);
  assign w_pop   = w_valid & i_pop;
  // When full, a same-cycle pop frees the slot the write lands in.
  assign w_push  = i_push & (~w_full | w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_drop   <= 1'b0;
    end else begin
      r_drop <= i_push & ~w_push;
      // Pointers wrap naturally: DEPTH is a power of two.
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; an empty buffer masks the head to zero instead.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = w_valid ? r_mem[r_rd_ptr] : '0;
  assign o_valid = w_valid;
  assign o_full  = w_full;
  assign o_count = r_count;
  assign o_drop  = r_drop;

endmodule

// File: rtl/mdr_result_stage.sv
// Purpose: formats MDR datapath results (mult/div/sqrt) and buffers them for a consumer.
// Latency: 1 cycle from i_flag to o_valid when the buffer is empty.
// Backpressure: holds head while i_ready low; strobes arriving when full are dropped (o_drop).
// Ports: clk, rst (async, active-high), bus (slave modport of mdr_result_stage_if).
module mdr_result_stage
  import pkg_system_mdr::*;
#(
  parameter int DW    = MDR_DW,
  parameter int DEPTH = MDR_DEPTH
) (
  input logic                clk,
  input logic                rst,
  mdr_result_stage_if.slave  bus
);

  typedef struct packed {
    logic [DW-1:0] data;
    logic [DW-1:0] rem;
    logic          err;
  } entry_t;

  logic [2*DW-1:0] w_p;
  logic [2*DW-1:0] w_pn;
  logic [DW-1:0]   w_lo;
  logic [DW-1:0]   w_hi;
  logic [DW:0]     w_top;
  logic            w_unused_acc0;
  entry_t          w_wr_entry;
  entry_t          w_rd_entry;

  // Bit 0 of the accumulator is a datapath guard bit, not part of the result.
  assign w_p           = bus.i_acc[2*DW:1];
  assign w_unused_acc0 = bus.i_acc[0];
  assign w_lo          = w_p[DW-1:0];
  assign w_hi          = w_p[2*DW-1:DW];
  assign w_pn          = bus.i_neg ? -w_p : w_p;
  // The signed product fits DW bits only if the high half is pure sign extension.
  assign w_top         = w_pn[2*DW-1:DW-1];

  always_comb begin
    w_wr_entry = '0;
    case (mdr_mode_e'(bus.i_mode))
      MULT: begin
        w_wr_entry.data = w_pn[DW-1:0];
        w_wr_entry.rem  = w_pn[2*DW-1:DW];
        w_wr_entry.err  = ~((&w_top) | ~(|w_top));
      end
      DIV: begin
        w_wr_entry.data = bus.i_neg  ? -w_lo : w_lo;
        w_wr_entry.rem  = bus.i_rneg ? -w_hi : w_hi;
        w_wr_entry.err  = bus.i_dz;
      end
      SQRT: begin
        w_wr_entry.data = w_lo;
        w_wr_entry.rem  = w_hi;
        w_wr_entry.err  = 1'b0;
      end
      default: begin
        w_wr_entry.err = 1'b1;
      end
    endcase
  end

  mdr_result_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (bus.i_flag),
    .i_wdata (w_wr_entry),
    .i_pop   (bus.i_ready),
    .o_rdata (w_rd_entry),
    .o_valid (bus.o_valid),
    .o_full  (bus.o_full),
    .o_count (bus.o_count),
    .o_drop  (bus.o_drop)
  );

  assign bus.o_data = w_rd_entry.data;
  assign bus.o_rem  = w_rd_entry.rem;
  assign bus.o_err  = w_rd_entry.err;

endmodule

// File: tb/tb_mdr_result_stage.sv
module tb_mdr_result_stage;
  import pkg_system_mdr::*;

  logic clk;
  logic rst;

  int n_tests = 0;
  int n_fail  = 0;

  result_entry_t exp_q[$];
  result_entry_t mon_e;

  mdr_result_stage_if #(.DW(16), .DEPTH(4)) bus ();

  mdr_result_stage #(.DW(16), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] mode, input logic [32:0] acc,
                       input logic neg, input logic rneg, input logic dz);
    bus.i_mode = mode;
    bus.i_acc  = acc;
    bus.i_neg  = neg;
    bus.i_rneg = rneg;
    bus.i_dz   = dz;
    bus.i_flag = 1'b1;
  endtask

  // One strobe whose result is expected to be accepted.
  task automatic send(input logic [1:0] mode, input logic [32:0] acc,
                      input logic neg, input logic rneg, input logic dz,
                      input logic [15:0] ed, input logic [15:0] er, input logic ee);
    result_entry_t e;
    e.data = ed;
    e.rem  = er;
    e.err  = ee;
    drive(mode, acc, neg, rneg, dz);
    exp_q.push_back(e);
    tick();
    bus.i_flag = 1'b0;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    bus.i_ready = 1'b1;
    while (exp_q.size() != 0 && k < 20) begin
      tick();
      k++;
    end
    chk({name, "_drained"}, exp_q.size(), 0);
    chk({name, "_valid_low"}, bus.o_valid, 0);
    chk({name, "_count_zero"}, bus.o_count, 0);
  endtask

  // Scoreboard monitor: every accepted head is compared against the queue.
  always @(negedge clk) begin
    if (!rst && bus.o_valid && bus.i_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL pop_unexpected: got data %h rem %h err %b, required no output",
                 bus.o_data, bus.o_rem, bus.o_err);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pop_data", bus.o_data, mon_e.data);
        chk("pop_rem",  bus.o_rem,  mon_e.rem);
        chk("pop_err",  bus.o_err,  mon_e.err);
      end
    end
  end

  initial begin
    logic [15:0] hi;
    logic [15:0] lo;

    rst         = 1'b1;
    bus.i_flag  = 1'b0;
    bus.i_mode  = 2'd0;
    bus.i_acc   = '0;
    bus.i_neg   = 1'b0;
    bus.i_rneg  = 1'b0;
    bus.i_dz    = 1'b0;
    bus.i_ready = 1'b0;

    // Reset state
    #3;
    chk("rst_valid", bus.o_valid, 0);
    chk("rst_count", bus.o_count, 0);
    chk("rst_full",  bus.o_full,  0);
    chk("rst_drop",  bus.o_drop,  0);
    chk("rst_data",  bus.o_data,  0);
    chk("rst_rem",   bus.o_rem,   0);
    chk("rst_err",   bus.o_err,   0);

    // Strobe coincident with reset is discarded
    drive(MULT, 33'h0_0000_000C, 1'b0, 1'b0, 1'b0);
    tick();
    rst        = 1'b0;
    bus.i_flag = 1'b0;
    tick();
    chk("rst_flag_discard_count", bus.o_count, 0);
    chk("rst_flag_discard_valid", bus.o_valid, 0);

    // Directed vectors, consumer ready
    bus.i_ready = 1'b1;
    send(MULT, 33'h0_0000_000D, 1'b1, 1'b0, 1'b0, 16'hFFFA, 16'hFFFF, 1'b0);
    chk("mult_neg_valid", bus.o_valid, 1);
    drain("mult_neg");
    send(MULT, 33'h0_0002_BF20, 1'b0, 1'b0, 1'b0, 16'h5F90, 16'h0001, 1'b1);
    drain("mult_ovf");
    send(MULT, 33'h0_0000_FFFE, 1'b0, 1'b0, 1'b0, 16'h7FFF, 16'h0000, 1'b0);
    drain("mult_maxpos");
    send(MULT, 33'h0_0001_0000, 1'b0, 1'b0, 1'b0, 16'h8000, 16'h0000, 1'b1);
    drain("mult_pos8000");
    send(MULT, 33'h0_0001_0000, 1'b1, 1'b0, 1'b0, 16'h8000, 16'hFFFF, 1'b0);
    drain("mult_neg8000");
    send(DIV, 33'h0_0002_0010, 1'b1, 1'b0, 1'b0, 16'hFFF8, 16'h0001, 1'b0);
    drain("div_neg");
    send(DIV, 33'h0_0002_0010, 1'b1, 1'b0, 1'b1, 16'hFFF8, 16'h0001, 1'b1);
    drain("div_dz");
    send(DIV, 33'h0_0006_000A, 1'b0, 1'b1, 1'b0, 16'h0005, 16'hFFFD, 1'b0);
    drain("div_rneg");
    send(SQRT, 33'h0_0004_0018, 1'b1, 1'b1, 1'b1, 16'h000C, 16'h0002, 1'b0);
    drain("sqrt");
    send(RSVD, 33'h1_FFFF_FFFF, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h0000, 1'b1);
    drain("rsvd");

    // Fill with consumer stalled: fifth strobe dropped
    bus.i_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      hi = 16'h0010 + 16'(i);
      lo = 16'h00A0 + 16'(i);
      send(SQRT, {hi, lo, 1'b0}, 1'b0, 1'b0, 1'b0, lo, hi, 1'b0);
    end
    chk("fill_count", bus.o_count, 4);
    chk("fill_full",  bus.o_full,  1);
    chk("fill_drop_before", bus.o_drop, 0);
    drive(SQRT, 33'h0_0099_0099, 1'b0, 1'b0, 1'b0);
    tick();
    bus.i_flag = 1'b0;
    chk("drop_pulse", bus.o_drop, 1);
    chk("drop_count", bus.o_count, 4);
    chk("stall_head_data", bus.o_data, 16'h00A0);
    chk("stall_head_rem",  bus.o_rem,  16'h0010);
    tick();
    chk("drop_one_cycle", bus.o_drop, 0);
    chk("stall_head_hold", bus.o_data, 16'h00A0);
    drain("fill");

    // Full buffer with simultaneous push and pop
    bus.i_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      hi = 16'h0020 + 16'(i);
      lo = 16'h00B0 + 16'(i);
      send(SQRT, {hi, lo, 1'b0}, 1'b0, 1'b0, 1'b0, lo, hi, 1'b0);
    end
    chk("full2_count", bus.o_count, 4);
    bus.i_ready = 1'b1;
    send(MULT, 33'h0_0000_0006, 1'b0, 1'b0, 1'b0, 16'h0003, 16'h0000, 1'b0);
    chk("pushpop_drop",  bus.o_drop,  0);
    chk("pushpop_count", bus.o_count, 4);
    chk("pushpop_full",  bus.o_full,  1);
    drain("pushpop");

    // Reset mid-cycle with two entries stored
    bus.i_ready = 1'b0;
    send(SQRT, 33'h0_0002_0002, 1'b0, 1'b0, 1'b0, 16'h0001, 16'h0001, 1'b0);
    send(SQRT, 33'h0_0004_0004, 1'b0, 1'b0, 1'b0, 16'h0002, 16'h0002, 1'b0);
    chk("pre_rst_count", bus.o_count, 2);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_valid", bus.o_valid, 0);
    chk("mid_rst_count", bus.o_count, 0);
    chk("mid_rst_data",  bus.o_data,  0);
    exp_q.delete();
    #1 rst = 1'b0;
    // First edge after reset release accepts a push
    bus.i_ready = 1'b1;
    send(DIV, 33'h0_0002_0010, 1'b0, 1'b0, 1'b0, 16'h0008, 16'h0001, 1'b0);
    chk("post_rst_valid", bus.o_valid, 1);
    chk("post_rst_count", bus.o_count, 1);
    drain("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
